// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch stage. Issues requests to instruction memory with a
// req/ack handshake, and loads the IF/ID pipeline register. A one-entry
// buffer catches an acknowledged instruction while decode stalls. The stage
// drops wrong-path data when a branch redirects while a request is in flight.
//
// Ports
//   i_clk, i_reset        rising-edge clock, async active-high reset
//   i_write_pc/_ifid      0 = hold (load-use stall)
//   i_pc_src              1 = taken-branch redirect to i_branch_target
//   o_imem_req/o_imem_addr fetch request and its address
//   i_imem_ack/i_imem_rdata memory response (ignored while o_imem_req=0)
//   o_ifid_instr/_pc4/_valid IF/ID pipeline register
//   o_fetch_busy          IF/ID refill waiting on memory
module fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter int                 INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_write_pc,
    input  logic               i_write_ifid,
    input  logic               i_pc_src,
    input  logic [ADDR_W-1:0]  i_branch_target,
    output logic               o_imem_req,
    output logic [ADDR_W-1:0]  o_imem_addr,
    input  logic               i_imem_ack,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic [INSTR_W-1:0] o_ifid_instr,
    output logic [ADDR_W-1:0]  o_ifid_pc4,
    output logic               o_ifid_valid,
    output logic               o_fetch_busy
);

    typedef enum logic [1:0] {
        ST_ISSUE = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DROP  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'd4};

    state_t              r_state,      w_state_n;
    logic [ADDR_W-1:0]   r_pc,         w_pc_n;
    logic [ADDR_W-1:0]   r_addr,       w_addr_n;
    logic [INSTR_W-1:0]  r_buf_instr,  w_buf_instr_n;
    logic [ADDR_W-1:0]   r_buf_pc4,    w_buf_pc4_n;
    logic [INSTR_W-1:0]  r_ifid_instr, w_ifid_instr_n;
    logic [ADDR_W-1:0]   r_ifid_pc4,   w_ifid_pc4_n;
    logic                r_ifid_valid, w_ifid_valid_n;
    // Low only during the first cycle after reset so that no request is
    // raised until reset has been seen released at a clock edge.
    logic                r_run;

    logic                w_ack;
    logic                w_stall;
    logic [ADDR_W-1:0]   w_addr_p4;

    // Request and busy are decodes of registered state only.
    assign o_imem_req   = r_run && (r_state != ST_HOLD);
    assign o_imem_addr  = r_addr;
    assign o_fetch_busy = r_run && (((r_state == ST_ISSUE) && !i_imem_ack) ||
                                    (r_state == ST_DROP));
    assign o_ifid_instr = r_ifid_instr;
    assign o_ifid_pc4   = r_ifid_pc4;
    assign o_ifid_valid = r_ifid_valid;

    assign w_ack     = i_imem_ack && o_imem_req;
    assign w_stall   = !i_write_pc || !i_write_ifid;
    assign w_addr_p4 = r_addr + PC_STEP;

    // State and datapath registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= ST_ISSUE;
            r_run        <= 1'b0;
            r_pc         <= RESET_PC;
            r_addr       <= RESET_PC;
            r_buf_instr  <= {INSTR_W{1'b0}};
            r_buf_pc4    <= {ADDR_W{1'b0}};
            r_ifid_instr <= {INSTR_W{1'b0}};
            r_ifid_pc4   <= {ADDR_W{1'b0}};
            r_ifid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_run        <= 1'b1;
            r_pc         <= w_pc_n;
            r_addr       <= w_addr_n;
            r_buf_instr  <= w_buf_instr_n;
            r_buf_pc4    <= w_buf_pc4_n;
            r_ifid_instr <= w_ifid_instr_n;
            r_ifid_pc4   <= w_ifid_pc4_n;
            r_ifid_valid <= w_ifid_valid_n;
        end
    end

    // Next-state and datapath update; priority is redirect > stall > normal.
    always_comb begin
        w_state_n      = r_state;
        w_pc_n         = r_pc;
        w_addr_n       = r_addr;
        w_buf_instr_n  = r_buf_instr;
        w_buf_pc4_n    = r_buf_pc4;
        w_ifid_instr_n = r_ifid_instr;
        w_ifid_pc4_n   = r_ifid_pc4;
        w_ifid_valid_n = r_ifid_valid;

        case (r_state)
            ST_ISSUE: begin
                if (i_pc_src) begin
                    w_ifid_valid_n = 1'b0;
                    w_pc_n         = i_branch_target;
                    if (w_ack) begin
                        w_addr_n = i_branch_target;
                    end else begin
                        // Request in flight cannot be aborted; eat its data.
                        w_state_n = ST_DROP;
                    end
                end else if (w_ack) begin
                    if (w_stall) begin
                        w_buf_instr_n = i_imem_rdata;
                        w_buf_pc4_n   = w_addr_p4;
                        w_state_n     = ST_HOLD;
                    end else begin
                        w_ifid_instr_n = i_imem_rdata;
                        w_ifid_pc4_n   = w_addr_p4;
                        w_ifid_valid_n = 1'b1;
                        w_pc_n         = w_addr_p4;
                        w_addr_n       = w_addr_p4;
                    end
                end else if (!w_stall) begin
                    w_ifid_valid_n = 1'b0;
                end else begin
                    w_ifid_valid_n = r_ifid_valid;
                end
            end
            ST_HOLD: begin
                if (i_pc_src) begin
                    w_ifid_valid_n = 1'b0;
                    w_pc_n         = i_branch_target;
                    w_addr_n       = i_branch_target;
                    w_state_n      = ST_ISSUE;
                end else if (!w_stall) begin
                    w_ifid_instr_n = r_buf_instr;
                    w_ifid_pc4_n   = r_buf_pc4;
                    w_ifid_valid_n = 1'b1;
                    w_pc_n         = r_buf_pc4;
                    w_addr_n       = r_buf_pc4;
                    w_state_n      = ST_ISSUE;
                end else begin
                    w_state_n = ST_HOLD;
                end
            end
            ST_DROP: begin
                w_ifid_valid_n = 1'b0;
                if (i_pc_src) begin
                    w_pc_n = i_branch_target;
                end else begin
                    w_pc_n = r_pc;
                end
                if (w_ack) begin
                    // Restart at the most recent redirect target.
                    w_addr_n  = i_pc_src ? i_branch_target : r_pc;
                    w_state_n = ST_ISSUE;
                end else begin
                    w_state_n = ST_DROP;
                end
            end
            default: begin
                w_state_n      = ST_ISSUE;
                w_ifid_valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by random traffic, all
// checked against a flag-based reference model of the fetch stage.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        write_pc;
    logic        write_ifid;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic        fetch_busy;

    int vectors;
    int miscompares;

    // Reference model
    bit          m_run;
    bit          m_drop;
    bit          m_buf_full;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] m_buf_instr;
    logic [31:0] m_buf_pc4;
    logic [31:0] m_instr;
    logic [31:0] m_pc4;
    bit          m_valid;

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_write_pc      (write_pc),
        .i_write_ifid    (write_ifid),
        .i_pc_src        (pc_src),
        .i_branch_target (branch_target),
        .o_imem_req      (imem_req),
        .o_imem_addr     (imem_addr),
        .i_imem_ack      (imem_ack),
        .i_imem_rdata    (imem_rdata),
        .o_ifid_instr    (ifid_instr),
        .o_ifid_pc4      (ifid_pc4),
        .o_ifid_valid    (ifid_valid),
        .o_fetch_busy    (fetch_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_drop = 0; m_buf_full = 0;
        m_pc = 32'h0; m_addr = 32'h0;
        m_buf_instr = 32'h0; m_buf_pc4 = 32'h0;
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'd0, imem_req},   32'd0);
        check({tag, "_addr"},  imem_addr,           32'h0);
        check({tag, "_busy"},  {31'd0, fetch_busy}, 32'd0);
        check({tag, "_valid"}, {31'd0, ifid_valid}, 32'd0);
        check({tag, "_instr"}, ifid_instr,          32'h0);
        check({tag, "_pc4"},   ifid_pc4,            32'h0);
    endtask

    // One clock: drive inputs, check request side, clock, update model, check IF/ID.
    task automatic cycle(input bit ack, input bit wpc, input bit wifid,
                         input bit psrc, input logic [31:0] tgt);
        bit exp_req;
        bit acc;
        bit stall;
        exp_req       = m_run && !m_buf_full;
        imem_ack      = ack;
        imem_rdata    = mem_word(m_addr);
        write_pc      = wpc;
        write_ifid    = wifid;
        pc_src        = psrc;
        branch_target = tgt;
        #1;
        check("req",  {31'd0, imem_req}, {31'd0, exp_req});
        if (exp_req) check("addr", imem_addr, m_addr);
        check("busy", {31'd0, fetch_busy},
              {31'd0, m_run && (m_drop || (!m_buf_full && !ack))});
        @(posedge clk);
        #1;
        acc   = ack && exp_req;
        stall = !wpc || !wifid;
        if (psrc) begin
            m_valid = 0;
            m_pc    = tgt;
            if (m_drop) begin
                if (acc) begin m_drop = 0; m_addr = tgt; end
            end else if (m_buf_full || acc) begin
                m_buf_full = 0;
                m_addr     = tgt;
            end else begin
                m_drop = 1;
            end
        end else if (m_drop) begin
            if (acc) begin m_drop = 0; m_addr = m_pc; end
        end else if (m_buf_full) begin
            if (!stall) begin
                m_instr = m_buf_instr; m_pc4 = m_buf_pc4; m_valid = 1;
                m_pc = m_buf_pc4; m_addr = m_buf_pc4; m_buf_full = 0;
            end
        end else if (acc) begin
            if (stall) begin
                m_buf_instr = mem_word(m_addr); m_buf_pc4 = m_addr + 32'd4;
                m_buf_full  = 1;
            end else begin
                m_instr = mem_word(m_addr); m_pc4 = m_addr + 32'd4; m_valid = 1;
                m_pc = m_addr + 32'd4; m_addr = m_addr + 32'd4;
            end
        end else if (!stall) begin
            m_valid = 0;
        end
        m_run = 1;
        check("ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
        check("ifid_pc4",   ifid_pc4,   m_pc4);
        check("ifid_instr", ifid_instr, m_instr);
    endtask

    task automatic do_reset();
        reset = 1'b1; imem_ack = 1'b0; pc_src = 1'b0;
        write_pc = 1'b1; write_ifid = 1'b1; branch_target = 32'h0;
        #1;
        model_reset();
        check_reset_outputs("rst");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        imem_rdata = 32'h0;
        do_reset();

        // Zero-wait stream from reset: startup cycle, then one per cycle.
        cycle(1, 1, 1, 0, 32'h0);
        check("startup_valid", {31'd0, ifid_valid}, 32'd0);
        cycle(1, 1, 1, 0, 32'h0);
        check("first_pc4", ifid_pc4, 32'h4);
        cycle(1, 1, 1, 0, 32'h0);
        check("second_pc4", ifid_pc4, 32'h8);
        // Load-use stall while 0x8 is acknowledged.
        cycle(1, 0, 0, 0, 32'h0);
        check("stall_hold_pc4", ifid_pc4, 32'h8);
        cycle(0, 1, 1, 0, 32'h0);
        check("after_stall_pc4", ifid_pc4, 32'hC);
        check("after_stall_instr", ifid_instr, mem_word(32'h8));
        cycle(1, 1, 1, 0, 32'h0);
        check("next_pc4", ifid_pc4, 32'h10);

        // Two-wait memory: ack every third request cycle.
        for (int i = 0; i < 9; i++) cycle((i % 3) == 2, 1, 1, 0, 32'h0);

        // Redirect while a request is pending.
        cycle(0, 1, 1, 1, 32'h100);
        cycle(0, 1, 1, 0, 32'h0);
        cycle(1, 1, 1, 0, 32'h0);
        check("drop_restart_addr", imem_addr, 32'h100);
        cycle(1, 1, 1, 0, 32'h0);
        check("target_pc4", ifid_pc4, 32'h104);

        // Redirect in HOLD with a simultaneous stall.
        cycle(1, 1, 0, 0, 32'h0);
        cycle(0, 1, 0, 1, 32'h200);
        check("hold_redirect_addr", imem_addr, 32'h200);
        cycle(1, 1, 1, 0, 32'h0);

        // Address wrap at the top of memory.
        cycle(1, 1, 1, 1, 32'hFFFF_FFFC);
        cycle(1, 1, 1, 0, 32'h0);
        check("wrap_pc4", ifid_pc4, 32'h0);
        cycle(1, 1, 1, 0, 32'h0);

        // Async reset while in DROP.
        cycle(0, 1, 1, 1, 32'h300);
        imem_ack = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_reset_outputs("mid_drop_rst");
        @(negedge clk);
        reset = 1'b0;
        cycle(1, 1, 1, 0, 32'h0);
        cycle(1, 1, 1, 0, 32'h0);
        check("restart_pc4", ifid_pc4, 32'h4);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            bit r_ack, r_wpc, r_wifid, r_psrc;
            logic [31:0] r_tgt;
            r_ack   = ($urandom_range(0, 9) < 6);
            r_wpc   = ($urandom_range(0, 9) != 0);
            r_wifid = ($urandom_range(0, 9) != 0);
            r_psrc  = ($urandom_range(0, 9) == 0);
            r_tgt   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            cycle(r_ack, r_wpc, r_wifid, r_psrc, r_tgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that drives the PC and the IF/ID pipeline register, and consumes the stall/flush controls issued by the decode-stage hazard logic. It runs a request/acknowledge handshake to instruction memory that may return in zero or more wait cycles. It holds an acknowledged instruction in a one-entry buffer while decode stalls, and squashes wrong-path fetches on a taken-branch redirect. Sits between PC/instruction memory and decode.

## Interface
- ADDR_W, 32, PC and memory address width
- INSTR_W, 32, instruction width
- RESET_PC, 32'h0, PC value after reset
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- write_PC  in  1  0 = hold PC (load-use stall)
- write_IFID  in  1  0 = hold IF/ID register (load-use stall)
- pc_src  in  1  1 = taken branch/jump redirect this cycle
- branch_target  in  ADDR_W  redirect address, valid when pc_src=1
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address, stable while imem_req=1 and no ack
- imem_ack  in  1  data valid; sampled only when imem_req=1
- imem_rdata  in  INSTR_W  instruction, valid with imem_ack
- ifid_instr  out  INSTR_W  IF/ID instruction
- ifid_pc4  out  ADDR_W  IF/ID PC+4
- ifid_valid  out  1  0 = bubble (decode treats as NOP)
- fetch_busy  out  1  1 = IF/ID refill pending on memory

## Operation
- stall = !write_PC || !write_IFID. Priority: reset > pc_src > stall > normal.
- Registers: pc, addr_q (outstanding request address), buffer (instr, pc4), state.
- States:
  - ISSUE: imem_req=1, imem_addr=addr_q.
  - HOLD: imem_req=0, buffer full.
  - DROP: imem_req=1, imem_addr=addr_q, returning data discarded.
- ISSUE, ack, no stall, no redirect: IF/ID <= {rdata, addr_q+4, valid=1}. pc, addr_q <= addr_q+4. Stay ISSUE.
- ISSUE, ack, stall: buffer <= {rdata, addr_q+4}. IF/ID unchanged. Go HOLD.
- ISSUE, no ack, no stall: IF/ID valid <= 0 (bubble). Stay ISSUE.
- ISSUE, no ack, stall: IF/ID unchanged. Stay ISSUE.
- HOLD, no stall: IF/ID <= buffer, valid=1. pc, addr_q <= buffer pc4. Go ISSUE.
- HOLD, stall: nothing changes.
- Redirect (pc_src=1) always sets IF/ID valid <= 0 and pc <= branch_target.
  - In ISSUE with ack, or in HOLD: discard the data/buffer, addr_q <= branch_target, go ISSUE.
  - In ISSUE without ack: an outstanding request cannot be aborted. Keep addr_q, go DROP.
  - In DROP: update pc only; the latest target wins.
- DROP, ack: discard rdata, addr_q <= pc, go ISSUE. IF/ID valid stays 0.
- DROP, no ack: IF/ID valid stays 0.
- Address arithmetic is modulo 2^ADDR_W: 32'hFFFFFFFC+4 = 0, no error.
- fetch_busy = (state==ISSUE && !imem_ack) || state==DROP.

## Timing
- Reset (async) forces: state=ISSUE, pc=addr_q=RESET_PC, ifid_valid=0, ifid_instr=0, ifid_pc4=0, buffer cleared.
  - Outputs during reset: imem_req=0, imem_addr=RESET_PC, fetch_busy=0.
  - First request is asserted in the cycle after reset deasserts.
- imem_req and imem_addr are registered-state decodes, never combinational from imem_ack.
- Zero-wait memory (ack in the request cycle): one instruction per cycle. Data acknowledged at edge k is visible on IF/ID after edge k.
- Ack while imem_req=0 is ignored.
- Stall is applied at the edge where it is sampled. The instruction acknowledged in that cycle is never lost or duplicated.
- Reset mid-request: the outstanding transaction is abandoned. Memory must tolerate a dropped request.

## Test plan
- Zero-wait, no stall, from reset: ack every cycle → ifid_pc4 sequence 4, 8, 12, …, ifid_valid=1 from the second cycle after reset release.
- 2-wait memory: ack every 3rd request cycle → two bubbles (ifid_valid=0) between valid instructions, fetch_busy=1 during waits.
- Load-use stall: write_PC=write_IFID=0 for 1 cycle while ack of 0x0000_0008 returns → IF/ID holds the 0x4 instruction, then shows 0x8's instruction, no skip or repeat.
- Redirect during wait: pc_src=1, branch_target=0x100 while request at 0x10 is pending → DROP, the 0x10 data is discarded, the next request is at 0x100, ifid_valid=0 until 0x100's data arrives.
- Redirect in HOLD with simultaneous stall: buffer discarded, next imem_addr=branch_target.
- Async reset asserted mid-DROP → all outputs immediately at reset values, fetch restarts at RESET_PC.
